// File: rtl/riscv_mem_arbiter_pkg.sv
// Shared types for the fetch/LSU memory arbiter: owner and sequencer state encodings.
package riscv_mem_pkg;
   localparam int LAT_CNT_W = 4;

   typedef enum logic {
      OWN_FETCH = 1'b0,
      OWN_DATA  = 1'b1
   } owner_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP
   } arb_state_e;
endpackage

// File: rtl/riscv_mem_arbiter_if.sv
// Fetch, load/store and memory-side signals of the arbiter, bundled as one bus.
interface riscv_mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   localparam int STRB_W = DATA_W / 8;

   logic              if_valid;
   logic [ADDR_W-1:0] if_addr;
   logic              if_ready;
   logic              if_resp_valid;
   logic [DATA_W-1:0] if_resp_rdata;

   logic              d_valid;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [STRB_W-1:0] d_wstrb;
   logic              d_ready;
   logic              d_resp_valid;
   logic [DATA_W-1:0] d_resp_rdata;

   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [STRB_W-1:0] mem_wstrb;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  if_valid, if_addr, d_valid, d_we, d_addr, d_wdata, d_wstrb, mem_rdata,
      output if_ready, if_resp_valid, if_resp_rdata, d_ready, d_resp_valid, d_resp_rdata,
      output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
   );

   modport master (
      output if_valid, if_addr, d_valid, d_we, d_addr, d_wdata, d_wstrb, mem_rdata,
      input  if_ready, if_resp_valid, if_resp_rdata, d_ready, d_resp_valid, d_resp_rdata,
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
   );
endinterface

// File: rtl/riscv_mem_arbiter_rr_arbiter2.sv
// Two-way round-robin pick: bit 0 = fetch, bit 1 = data; on contention the
// requester that did not win last time is granted.
module rr_arbiter2
   import riscv_mem_pkg::*;
(
   input  logic [1:0] req_i,
   input  owner_e     last_grant_i,
   output logic [1:0] grant_o
);
   always_comb begin
      grant_o = 2'b00;
      case (req_i)
         2'b01:   grant_o = 2'b01;
         2'b10:   grant_o = 2'b10;
         2'b11:   grant_o = (last_grant_i == OWN_DATA) ? 2'b01 : 2'b10;
         default: grant_o = 2'b00;
      endcase
   end
endmodule

// File: rtl/riscv_mem_arbiter.sv
// Shares one fixed-latency single-port RAM between instruction fetch and the LSU,
// one transaction in flight at a time.
//   state   | meaning
//   S_IDLE  | no transaction; arbitrate and accept
//   S_ISSUE | mem_req strobe with captured request
//   S_WAIT  | count down MEM_LATENCY-1, then capture mem_rdata
//   S_RESP  | owner's resp_valid pulse; also arbitrates like S_IDLE
module riscv_mem_arbiter
   import riscv_mem_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int MEM_LATENCY = 1
) (
   input  logic                clk,
   input  logic                reset,
   riscv_mem_arbiter_if.slave  bus
);
   localparam int STRB_W = DATA_W / 8;
   localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(MEM_LATENCY - 1);

   arb_state_e        state_q, state_d;
   owner_e            owner_q, owner_d;
   owner_e            last_grant_q, last_grant_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              we_q, we_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [STRB_W-1:0] wstrb_q, wstrb_d;
   logic [LAT_CNT_W-1:0] cnt_q, cnt_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
   logic [1:0]        grant;
   logic              accept_en;

   rr_arbiter2 u_rr (
      .req_i        ({bus.d_valid, bus.if_valid}),
      .last_grant_i (last_grant_q),
      .grant_o      (grant)
   );

   // Ready is masked during reset so nothing is accepted while the FSM is being cleared.
   assign accept_en = ((state_q == S_IDLE) || (state_q == S_RESP)) && !reset;

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      addr_d       = addr_q;
      we_d         = we_q;
      wdata_d      = wdata_q;
      wstrb_d      = wstrb_q;
      cnt_d        = cnt_q;
      if_rdata_d   = if_rdata_q;
      d_rdata_d    = d_rdata_q;
      case (state_q)
         S_IDLE, S_RESP: begin
            state_d = S_IDLE;
            if (grant[0]) begin
               owner_d      = OWN_FETCH;
               last_grant_d = OWN_FETCH;
               addr_d       = bus.if_addr;
               we_d         = 1'b0;
               wstrb_d      = '0;
               state_d      = S_ISSUE;
            end else if (grant[1]) begin
               owner_d      = OWN_DATA;
               last_grant_d = OWN_DATA;
               addr_d       = bus.d_addr;
               we_d         = bus.d_we;
               wdata_d      = bus.d_wdata;
               wstrb_d      = bus.d_wstrb;
               state_d      = S_ISSUE;
            end
         end
         S_ISSUE: begin
            cnt_d   = LAT_LOAD;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - LAT_CNT_W'(1);
            end else begin
               if (owner_q == OWN_FETCH) if_rdata_d = bus.mem_rdata;
               else                      d_rdata_d  = bus.mem_rdata;
               state_d = S_RESP;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         owner_q      <= OWN_FETCH;
         last_grant_q <= OWN_DATA;
         addr_q       <= '0;
         we_q         <= 1'b0;
         wdata_q      <= '0;
         wstrb_q      <= '0;
         cnt_q        <= '0;
         if_rdata_q   <= '0;
         d_rdata_q    <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         addr_q       <= addr_d;
         we_q         <= we_d;
         wdata_q      <= wdata_d;
         wstrb_q      <= wstrb_d;
         cnt_q        <= cnt_d;
         if_rdata_q   <= if_rdata_d;
         d_rdata_q    <= d_rdata_d;
      end
   end

   assign bus.if_ready      = accept_en && grant[0];
   assign bus.d_ready       = accept_en && grant[1];
   assign bus.if_resp_valid = (state_q == S_RESP) && (owner_q == OWN_FETCH);
   assign bus.d_resp_valid  = (state_q == S_RESP) && (owner_q == OWN_DATA);
   assign bus.if_resp_rdata = if_rdata_q;
   assign bus.d_resp_rdata  = d_rdata_q;
   assign bus.mem_req       = (state_q == S_ISSUE);
   assign bus.mem_we        = (state_q == S_ISSUE) && we_q;
   assign bus.mem_wstrb     = (state_q == S_ISSUE) ? wstrb_q : '0;
   assign bus.mem_addr      = addr_q;
   assign bus.mem_wdata     = wdata_q;
endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Scoreboard bench: three arbiter instances with MEM_LATENCY 1, 2 and 3 behind a simple RAM model.
module tb_riscv_mem_arbiter;
   import riscv_mem_pkg::*;

   localparam int NL = 3;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   logic             if_valid_s [NL];
   logic [31:0]      if_addr_s  [NL];
   logic             d_valid_s  [NL];
   logic             d_we_s     [NL];
   logic [31:0]      d_addr_s   [NL];
   logic [31:0]      d_wdata_s  [NL];
   logic [3:0]       d_wstrb_s  [NL];
   logic [31:0]      mem_rdata_s[NL];

   logic [NL-1:0]    if_ready_w, d_ready_w, if_rv_w, d_rv_w, mem_req_w, mem_we_w;
   logic [31:0]      if_rd_w[NL], d_rd_w[NL], mem_addr_w[NL], mem_wdata_w[NL];
   logic [3:0]       mem_wstrb_w[NL];

   for (genvar g = 0; g < NL; g++) begin : lane
      riscv_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
      assign bus.if_valid  = if_valid_s[g];
      assign bus.if_addr   = if_addr_s[g];
      assign bus.d_valid   = d_valid_s[g];
      assign bus.d_we      = d_we_s[g];
      assign bus.d_addr    = d_addr_s[g];
      assign bus.d_wdata   = d_wdata_s[g];
      assign bus.d_wstrb   = d_wstrb_s[g];
      assign bus.mem_rdata = mem_rdata_s[g];
      assign if_ready_w[g]  = bus.if_ready;
      assign d_ready_w[g]   = bus.d_ready;
      assign if_rv_w[g]     = bus.if_resp_valid;
      assign d_rv_w[g]      = bus.d_resp_valid;
      assign if_rd_w[g]     = bus.if_resp_rdata;
      assign d_rd_w[g]      = bus.d_resp_rdata;
      assign mem_req_w[g]   = bus.mem_req;
      assign mem_we_w[g]    = bus.mem_we;
      assign mem_addr_w[g]  = bus.mem_addr;
      assign mem_wdata_w[g] = bus.mem_wdata;
      assign mem_wstrb_w[g] = bus.mem_wstrb;

      riscv_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(g + 1)) dut (
         .clk   (clk),
         .reset (reset),
         .bus   (bus)
      );
   end

   // RAM model: read data appears only in the cycle exactly L after mem_req
   logic [31:0] mem [logic [31:0]];
   int          due     [NL];
   logic [31:0] pend    [NL];
   int          req_cnt [NL];

   always @(negedge clk) begin
      for (int l = 0; l < NL; l++) begin
         if (mem_req_w[l]) begin
            due[l]  = cyc + l + 1;
            pend[l] = mem.exists(mem_addr_w[l]) ? mem[mem_addr_w[l]] : 32'hDEAD_BEEF;
            req_cnt[l]++;
         end
         mem_rdata_s[l] = (cyc == due[l]) ? pend[l] : 32'hBAD0_BAD0;
      end
   end

   typedef struct {
      int          lane;
      bit          fetch;
      bit          chkd;
      logic [31:0] data;
      int          cyc;
   } exp_t;
   exp_t sb[$];

   always @(negedge clk) begin
      for (int l = 0; l < NL; l++) begin
         if (if_rv_w[l] && d_rv_w[l]) begin
            checks++; errors++;
            $display("FAIL both_resp lane %0d cycle %0d: both resp_valid high, required at most one", l, cyc);
         end else if (if_rv_w[l] || d_rv_w[l]) begin
            exp_t e;
            logic [31:0] got;
            checks++;
            got = if_rv_w[l] ? if_rd_w[l] : d_rd_w[l];
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_resp lane %0d fetch=%0d cycle %0d: got response, required none",
                        l, if_rv_w[l], cyc);
            end else begin
               e = sb.pop_front();
               if (e.lane != l || e.fetch != if_rv_w[l] || e.cyc != cyc || (e.chkd && e.data != got)) begin
                  errors++;
                  $display("FAIL resp: got lane %0d fetch=%0d cycle %0d data %h, required lane %0d fetch=%0d cycle %0d data %h",
                           l, if_rv_w[l], cyc, got, e.lane, e.fetch, e.cyc, e.data);
               end
            end
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, got, exp);
      end
   endtask

   task automatic do_req(input int l, input bit fetch, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb,
                         input logic [31:0] exp, input bit push, output int acc);
      int n = 0;
      bit got = 0;
      if (fetch) begin
         if_valid_s[l] = 1'b1; if_addr_s[l] = addr;
      end else begin
         d_valid_s[l] = 1'b1; d_we_s[l] = we; d_addr_s[l] = addr;
         d_wdata_s[l] = wdata; d_wstrb_s[l] = wstrb;
      end
      while (!got && n < 30) begin
         @(negedge clk);
         n++;
         if (fetch ? if_ready_w[l] : d_ready_w[l]) got = 1;
      end
      checks++;
      acc = -1;
      if (!got) begin
         errors++;
         $display("FAIL accept_timeout lane %0d fetch=%0d: got no ready in 30 cycles, required ready", l, fetch);
      end else begin
         acc = cyc;
         if (push) sb.push_back('{lane: l, fetch: fetch, chkd: !we, data: exp, cyc: cyc + 3 + l});
      end
      @(posedge clk); #1;
      if (fetch) if_valid_s[l] = 1'b0;
      else       d_valid_s[l]  = 1'b0;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (sb.size() != 0 && n < 40) begin
         @(posedge clk);
         n++;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL %s_drain: got %0d responses outstanding, required 0", name, sb.size());
         sb.delete();
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   logic [31:0] ld_data [3];
   int acc, prev, k, n, c0;

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish by 200us, required finish");
      $fatal(1, "timeout");
   end

   initial begin
      for (int l = 0; l < NL; l++) begin
         if_valid_s[l] = 1'b1; if_addr_s[l] = '0;
         d_valid_s[l] = 1'b1; d_we_s[l] = 1'b0; d_addr_s[l] = '0;
         d_wdata_s[l] = '0; d_wstrb_s[l] = '0; mem_rdata_s[l] = '0;
         due[l] = -1; pend[l] = '0; req_cnt[l] = 0;
      end
      mem[32'h10]  = 32'h0050_0093;
      mem[32'h20]  = 32'hF00D_0001;
      mem[32'h300] = 32'hDA7A_0001;
      mem[32'h200] = 32'h11;
      mem[32'h204] = 32'h22;
      mem[32'h208] = 32'h33;
      mem[32'h44]  = 32'h4444_0044;
      ld_data[0] = 32'h11; ld_data[1] = 32'h22; ld_data[2] = 32'h33;

      // reset held with both requesters pending
      reset = 1'b1;
      repeat (4) begin
         @(negedge clk);
         for (int l = 0; l < NL; l++) begin
            chk("reset_ctrl", {if_ready_w[l], d_ready_w[l], if_rv_w[l], d_rv_w[l], mem_req_w[l],
                               mem_we_w[l], mem_wstrb_w[l]}, '0);
            chk("reset_addr_wdata", {mem_addr_w[l], mem_wdata_w[l]}, '0);
            chk("reset_rdata", {if_rd_w[l], d_rd_w[l]}, '0);
         end
      end
      @(posedge clk); #1;
      for (int l = 0; l < NL; l++) begin
         if_valid_s[l] = 1'b0; d_valid_s[l] = 1'b0;
      end
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // L=1 fetch
      do_req(0, 1'b1, 1'b0, 32'h10, '0, '0, 32'h0050_0093, 1'b1, acc);
      @(negedge clk);
      chk("t2_issue_cycle", 64'(cyc - acc), 64'd1);
      chk("t2_mem_req_we_strb", {mem_req_w[0], mem_we_w[0], mem_wstrb_w[0]}, {1'b1, 1'b0, 4'b0000});
      chk("t2_mem_addr", mem_addr_w[0], 32'h10);
      drain("t2");

      // L=1 store
      do_req(0, 1'b0, 1'b1, 32'h100, 32'h0000_AB00, 4'b0010, '0, 1'b1, acc);
      @(negedge clk);
      chk("t3_mem_req_we_strb", {mem_req_w[0], mem_we_w[0], mem_wstrb_w[0]}, {1'b1, 1'b1, 4'b0010});
      chk("t3_mem_addr", mem_addr_w[0], 32'h100);
      chk("t3_mem_wdata", mem_wdata_w[0], 32'h0000_AB00);
      @(negedge clk);
      chk("t3_wait_strobes", {mem_req_w[0], mem_we_w[0], mem_wstrb_w[0]}, '0);
      drain("t3");
      chk("t3_if_rdata_hold", if_rd_w[0], 32'h0050_0093);

      // L=2 continuous contention
      if_valid_s[1] = 1'b1; if_addr_s[1] = 32'h20;
      d_valid_s[1] = 1'b1; d_we_s[1] = 1'b0; d_addr_s[1] = 32'h300;
      k = 0; n = 0; prev = 0;
      while (k < 4 && n < 60) begin
         @(negedge clk);
         n++;
         if (if_ready_w[1] || d_ready_w[1]) begin
            chk("t4_grant", {if_ready_w[1], d_ready_w[1]}, (k % 2 == 0) ? 2'b10 : 2'b01);
            if (k > 0) chk("t4_spacing", 64'(cyc - prev), 64'd4);
            sb.push_back('{lane: 1, fetch: if_ready_w[1], chkd: 1'b1,
                           data: if_ready_w[1] ? 32'hF00D_0001 : 32'hDA7A_0001, cyc: cyc + 4});
            prev = cyc;
            k++;
         end
      end
      chk("t4_accepts", 64'(k), 64'd4);
      @(posedge clk); #1;
      if_valid_s[1] = 1'b0; d_valid_s[1] = 1'b0;
      drain("t4");

      // L=2 back-to-back loads
      c0 = req_cnt[1];
      prev = -1;
      for (int i = 0; i < 3; i++) begin
         do_req(1, 1'b0, 1'b0, 32'h200 + 32'(4 * i), '0, '0, ld_data[i], 1'b1, acc);
         if (i > 0) chk("t6_spacing", 64'(acc - prev), 64'd4);
         prev = acc;
      end
      drain("t6");
      chk("t6_mem_req_count", 64'(req_cnt[1] - c0), 64'd3);
      chk("t6_last_rdata", d_rd_w[1], 32'h33);

      // L=3 reset during WAIT, then contention must favour fetch again
      do_req(2, 1'b1, 1'b0, 32'h40, '0, '0, '0, 1'b0, acc);
      @(posedge clk); #1;
      reset = 1'b1;
      if_valid_s[2] = 1'b1; if_addr_s[2] = 32'h44;
      d_valid_s[2] = 1'b1; d_we_s[2] = 1'b0; d_addr_s[2] = 32'h300;
      repeat (3) begin
         @(negedge clk);
         chk("t5_reset_outs", {if_ready_w[2], d_ready_w[2], if_rv_w[2], d_rv_w[2], mem_req_w[2]}, '0);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      n = 0;
      while (!(if_ready_w[2] || d_ready_w[2]) && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("t5_grant_after_reset", {if_ready_w[2], d_ready_w[2]}, 2'b10);
      if (if_ready_w[2])
         sb.push_back('{lane: 2, fetch: 1'b1, chkd: 1'b1, data: 32'h4444_0044, cyc: cyc + 5});
      @(posedge clk); #1;
      if_valid_s[2] = 1'b0; d_valid_s[2] = 1'b0;
      drain("t5");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
